// File: rtl/link_round_ctrl_if.sv
// Front-end and peer-link signal bundle for the round sequencer.
// The slave side is the sequencer; the master side is whatever drives
// the menu pulses and the Pmod peer lines (board glue or a bench).
interface link_round_ctrl_if;
    // front end (mouse/menu)
    logic       pick_valid;
    logic [3:0] pick_id;
    logic       guess_valid;
    logic [3:0] guess_id;
    logic       new_round;
    // peer board, asynchronous to clk
    logic       peer_present_in;
    logic       peer_rdy_in;
    logic [3:0] peer_id_in;
    // to peer board and game/drawing logic
    logic       rdy_out;
    logic [3:0] id_out;
    logic [5:0] state_bin;
    logic [1:0] result;
    logic       link_err;

    modport master (
        output pick_valid, pick_id, guess_valid, guess_id, new_round,
        output peer_present_in, peer_rdy_in, peer_id_in,
        input  rdy_out, id_out, state_bin, result, link_err
    );

    modport slave (
        input  pick_valid, pick_id, guess_valid, guess_id, new_round,
        input  peer_present_in, peer_rdy_in, peer_id_in,
        output rdy_out, id_out, state_bin, result, link_err
    );
endinterface

// File: rtl/link_round_ctrl.sv
// Round sequencer for the two-board guessing game: pick, peer handshake,
// guess, resolve. Owns all inter-board synchronisation, qualification
// and timeout. Every output comes straight from a flip-flop.
module link_round_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 65_000_000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             rst,
    link_round_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // State encoding doubles as the one-hot state_bin seen by the game logic.
    typedef enum logic [5:0] {
        PICK      = 6'b000001,
        WAIT_PEER = 6'b000010,
        GUESS     = 6'b000100,
        CHECK     = 6'b001000,
        WIN       = 6'b010000,
        LOSE      = 6'b100000
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] present_sync;
    logic [SYNC_STAGES-1:0] rdy_sync;
    logic [3:0]             id_sync [SYNC_STAGES];

    logic       peer_present_s;
    logic       peer_rdy_s;
    logic [3:0] peer_id_s;
    logic       peer_rdy_d;
    logic       peer_qual;

    logic [CNT_W-1:0] cnt;

    logic [3:0] own_id,    own_id_n;
    logic [3:0] guess_q,   guess_n;
    logic [3:0] peer_id_q, peer_id_n;
    logic       rdy_q,     rdy_n;
    logic [1:0] result_q,  result_n;
    logic       err_q,     err_n;

    function automatic logic id_legal(input logic [3:0] id);
        return (id >= 4'd1) && (id <= 4'd9);
    endfunction

    // Multi-flop synchronisers on every asynchronous peer line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            present_sync <= '0;
            rdy_sync     <= '0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                id_sync[i] <= '0;
            end
        end else begin
            present_sync <= {present_sync[SYNC_STAGES-2:0], bus.peer_present_in};
            rdy_sync     <= {rdy_sync[SYNC_STAGES-2:0], bus.peer_rdy_in};
            id_sync[0]   <= bus.peer_id_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                id_sync[i] <= id_sync[i-1];
            end
        end
    end

    assign peer_present_s = present_sync[SYNC_STAGES-1];
    assign peer_rdy_s     = rdy_sync[SYNC_STAGES-1];
    assign peer_id_s      = id_sync[SYNC_STAGES-1];

    // One-cycle delayed ready so a single-cycle glitch never qualifies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peer_rdy_d <= 1'b0;
        end else begin
            peer_rdy_d <= peer_rdy_s;
        end
    end

    assign peer_qual = peer_present_s & peer_rdy_s & peer_rdy_d;

    // Peer wait timer: held at zero outside WAIT_PEER, saturates at terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state != WAIT_PEER) begin
            cnt <= '0;
        end else if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PICK;
            own_id    <= '0;
            guess_q   <= '0;
            peer_id_q <= '0;
            rdy_q     <= 1'b0;
            result_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            own_id    <= own_id_n;
            guess_q   <= guess_n;
            peer_id_q <= peer_id_n;
            rdy_q     <= rdy_n;
            result_q  <= result_n;
            err_q     <= err_n;
        end
    end

    // Next-state and next-output logic for the round phases.
    always_comb begin
        state_n   = state;
        own_id_n  = own_id;
        guess_n   = guess_q;
        peer_id_n = peer_id_q;
        rdy_n     = rdy_q;
        result_n  = result_q;
        err_n     = err_q;

        case (state)
            PICK: begin
                if (bus.pick_valid && id_legal(bus.pick_id)) begin
                    own_id_n = bus.pick_id;
                    rdy_n    = 1'b1;
                    err_n    = 1'b0;
                    state_n  = WAIT_PEER;
                end
            end
            WAIT_PEER: begin
                // qualification is tested first so it wins over the terminal count
                if (peer_qual) begin
                    peer_id_n = peer_id_s;
                    state_n   = GUESS;
                end else if (cnt == CNT_LAST) begin
                    rdy_n   = 1'b0;
                    err_n   = 1'b1;
                    state_n = PICK;
                end
            end
            GUESS: begin
                if (!peer_rdy_s || !peer_present_s) begin
                    rdy_n   = 1'b0;
                    err_n   = 1'b1;
                    state_n = PICK;
                end else if (bus.guess_valid && id_legal(bus.guess_id)) begin
                    guess_n = bus.guess_id;
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (guess_q == peer_id_q) begin
                    result_n = 2'b10;
                    state_n  = WIN;
                end else begin
                    result_n = 2'b01;
                    state_n  = LOSE;
                end
            end
            WIN, LOSE: begin
                if (bus.new_round) begin
                    result_n = 2'b00;
                    rdy_n    = 1'b0;
                    state_n  = PICK;
                end
            end
            default: begin
                state_n = PICK;
            end
        endcase
    end

    assign bus.rdy_out   = rdy_q;
    assign bus.id_out    = own_id;
    assign bus.state_bin = state;
    assign bus.result    = result_q;
    assign bus.link_err  = err_q;

endmodule

// File: tb/tb_link_round_ctrl.sv
// Scoreboard bench for link_round_ctrl: randomized rounds push expected
// output events (with the cycle they must appear on) into a queue; a
// negedge monitor pops one entry whenever any DUT output changes.
module tb_link_round_ctrl;

    localparam int unsigned T = 16;
    localparam int unsigned S = 2;

    localparam logic [5:0] ST_PICK  = 6'b000001;
    localparam logic [5:0] ST_WAIT  = 6'b000010;
    localparam logic [5:0] ST_GUESS = 6'b000100;
    localparam logic [5:0] ST_CHECK = 6'b001000;
    localparam logic [5:0] ST_WIN   = 6'b010000;
    localparam logic [5:0] ST_LOSE  = 6'b100000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    link_round_ctrl_if bus();

    link_round_ctrl #(
        .TIMEOUT_CYCLES(T),
        .SYNC_STAGES   (S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [5:0] st;
        logic [1:0] res;
        logic       rdy;
        logic [3:0] id;
        logic       err;
    } ev_t;

    ev_t        expq[$];
    logic [3:0] m_id = 4'd0;

    function automatic void exp_ev(int c, logic [5:0] st, logic [1:0] res, logic rdy, logic err);
        ev_t e;
        e.cyc = c;
        e.st  = st;
        e.res = res;
        e.rdy = rdy;
        e.id  = m_id;
        e.err = err;
        expq.push_back(e);
    endfunction

    // Monitor: any output change must match the next scheduled event.
    logic [13:0] prev_obs = '0;
    always @(negedge clk) begin
        logic [13:0] cur;
        logic [13:0] want;
        ev_t         e;
        cur = {bus.state_bin, bus.result, bus.rdy_out, bus.id_out, bus.link_err};
        if (!rst && cur !== prev_obs) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got=%b expected no change", cyc, cur);
            end else begin
                e    = expq.pop_front();
                want = {e.st, e.res, e.rdy, e.id, e.err};
                if (cur !== want || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL event cyc got=%0d expected=%0d outputs(state,res,rdy,id,err) got=%b expected=%b",
                             cyc, e.cyc, cur, want);
                end
            end
        end
        prev_obs = cur;
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_pick(logic [3:0] id);
        bus.pick_id    = id;
        bus.pick_valid = 1'b1;
        step();
        bus.pick_valid = 1'b0;
    endtask

    task automatic pulse_guess(logic [3:0] id);
        bus.guess_id    = id;
        bus.guess_valid = 1'b1;
        step();
        bus.guess_valid = 1'b0;
    endtask

    task automatic pulse_new_round();
        bus.new_round = 1'b1;
        step();
        bus.new_round = 1'b0;
    endtask

    task automatic check_reset(string name);
        logic [13:0] got;
        logic [13:0] want;
        got  = {bus.state_bin, bus.result, bus.rdy_out, bus.id_out, bus.link_err};
        want = {ST_PICK, 2'b00, 1'b0, 4'd0, 1'b0};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, got, want);
        end
    endtask

    // One round. d: idle cycles before the peer raises ready.
    // mode 0: finish with new_round, 1: peer lost in GUESS, 2: async reset in WIN/LOSE.
    // want 0: random guess, 1: force win, 2: force lose.
    task automatic run_round(int d, bit glitch_in, int mode, int want);
        int   n;
        int   q;
        int   g;
        bit   qual;
        bit   won;
        bit   glitch;
        logic [3:0] qid;
        logic [3:0] gid;

        glitch = glitch_in && (d >= 3);

        // ignored inputs while in PICK
        if ($urandom_range(0, 1) == 1)
            pulse_pick(($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(10, 15)));
        pulse_guess(4'($urandom_range(1, 9)));
        pulse_new_round();

        m_id = 4'($urandom_range(1, 9));
        qid  = 4'($urandom_range(1, 9));
        n    = cyc + 1;
        // peer ready first sampled at edge n+d+1, qualified S+1 edges later
        q    = n + d + int'(S) + 2;
        qual = (q <= n + int'(T));
        exp_ev(n, ST_WAIT, 2'b00, 1'b1, 1'b0);
        if (qual) exp_ev(q, ST_GUESS, 2'b00, 1'b1, 1'b0);
        else      exp_ev(n + int'(T), ST_PICK, 2'b00, 1'b0, 1'b1);

        pulse_pick(m_id);
        for (int i = 0; i < d; i++) begin
            bus.peer_rdy_in = glitch && (i == 1);
            bus.peer_id_in  = 4'($urandom_range(0, 15));
            step();
        end
        bus.peer_id_in  = qid;
        bus.peer_rdy_in = 1'b1;

        if (!qual) begin
            while (cyc < n + int'(T)) step();
            bus.peer_rdy_in = 1'b0;
            step(int'(S) + 3);
            return;
        end
        while (cyc < q) step();

        if (mode == 1) begin
            if ($urandom_range(0, 1) == 1) bus.peer_rdy_in = 1'b0;
            else                           bus.peer_present_in = 1'b0;
            step(int'(S));
            exp_ev(cyc + 1, ST_PICK, 2'b00, 1'b0, 1'b1);
            pulse_guess(4'($urandom_range(1, 9)));
            bus.peer_present_in = 1'b1;
            bus.peer_rdy_in     = 1'b0;
            step(int'(S) + 3);
            return;
        end

        // ignored inputs while in GUESS
        if ($urandom_range(0, 1) == 1)
            pulse_guess(($urandom_range(0, 1) == 1) ? 4'd15 : 4'd0);
        pulse_pick(4'($urandom_range(1, 9)));

        case (want)
            1:       gid = qid;
            2:       gid = (qid == 4'd9) ? 4'd1 : qid + 4'd1;
            default: gid = ($urandom_range(0, 1) == 1) ? qid : 4'($urandom_range(1, 9));
        endcase
        won = (gid == qid);
        g   = cyc + 1;
        exp_ev(g, ST_CHECK, 2'b00, 1'b1, 1'b0);
        exp_ev(g + 1, won ? ST_WIN : ST_LOSE, won ? 2'b10 : 2'b01, 1'b1, 1'b0);
        pulse_guess(gid);

        // peer activity after the result must not disturb it
        bus.peer_rdy_in = 1'b0;
        bus.peer_id_in  = 4'($urandom_range(0, 15));
        step(2 + int'($urandom_range(0, 3)));

        if (mode == 2) begin
            #1;
            rst = 1'b1;
            #1;
            check_reset("reset_mid_round");
            m_id = 4'd0;
            step();
            rst = 1'b0;
            step(int'(S) + 3);
        end else begin
            exp_ev(cyc + 1, ST_PICK, 2'b00, 1'b0, 1'b0);
            pulse_new_round();
            step(int'(S) + 3);
        end
    endtask

    initial begin
        int r;
        ev_t e;
        bus.pick_valid      = 1'b0;
        bus.pick_id         = 4'd0;
        bus.guess_valid     = 1'b0;
        bus.guess_id        = 4'd0;
        bus.new_round       = 1'b0;
        bus.peer_present_in = 1'b1;
        bus.peer_rdy_in     = 1'b0;
        bus.peer_id_in      = 4'd0;

        step(2);
        check_reset("reset_init");
        rst = 1'b0;
        step(3);

        // directed: win, lose, boundary of qualification vs timeout, glitch, loss, reset
        run_round(1,  1'b0, 0, 1);
        run_round(2,  1'b0, 0, 2);
        run_round(int'(T) - int'(S) - 2, 1'b0, 0, 0);
        run_round(int'(T) - int'(S) - 1, 1'b0, 0, 0);
        run_round(int'(T) + 4, 1'b0, 0, 0);
        run_round(6,  1'b1, 0, 0);
        run_round(4,  1'b0, 1, 0);
        run_round(3,  1'b0, 2, 1);

        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 5));
            run_round(int'($urandom_range(0, T + 4)), $urandom_range(0, 1) == 1,
                      (r == 0) ? 1 : ((r == 1) ? 2 : 0), 0);
        end

        step(5);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event expected cyc=%0d state=%b got no change", e.cyc, e.st);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/link_round_ctrl.md
# link_round_ctrl

Round sequencer for the two-board guessing game. It steps one round through four phases: pick own person, handshake with the peer board over the Pmod link, guess, and resolve. It drives the 6-bit `state_bin` used by the game and drawing logic, the outgoing Pmod ready/ID lines and the round result. It sits between the mouse/menu front end and the Pmod connectors and owns all inter-board timing: synchronisation, qualification and timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, 65_000_000: maximum cycles spent waiting for the peer (1 s at 65 MHz).
- SYNC_STAGES, 2: flip-flop stages on every peer input; legal range 2..4.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- pick_valid  input  1  one-cycle pulse: player confirmed own person
- pick_id  input  4  own person, legal 1..9
- guess_valid  input  1  one-cycle pulse: player clicked a guess
- guess_id  input  4  guessed person, legal 1..9
- new_round  input  1  one-cycle pulse: start next round from WIN/LOSE
- peer_present_in  input  1  asynchronous; peer board drives constant 1 when connected
- peer_rdy_in  input  1  asynchronous; peer has picked its person
- peer_id_in  input  4  asynchronous; peer's person, stable while peer_rdy_in=1
- rdy_out  output  1  to peer: own pick latched
- id_out  output  4  to peer: own person
- state_bin  output  6  one-hot phase code
- result  output  2  2'b10 = win, 2'b01 = lose, 2'b00 = none
- link_err  output  1  sticky: timeout or peer lost

## Operation
- All peer inputs pass through SYNC_STAGES flip-flops. The synchronised outputs are peer_present_s, peer_rdy_s and peer_id_s.
- peer_rdy_d is peer_rdy_s delayed by one cycle. Peer is qualified when peer_present_s & peer_rdy_s & peer_rdy_d.
- States and their state_bin codes:
  - PICK = 6'b000001
  - WAIT_PEER = 6'b000010
  - GUESS = 6'b000100
  - CHECK = 6'b001000
  - WIN = 6'b010000
  - LOSE = 6'b100000
- PICK:
  - On pick_valid with pick_id in 1..9: latch own_id, id_out=own_id, rdy_out=1, link_err=0, go to WAIT_PEER.
  - pick_id of 0 or 10..15 is ignored; state is unchanged.
  - guess_valid and new_round are ignored.
- WAIT_PEER:
  - Timeout counter is cleared on entry and increments every cycle in this state.
  - If peer is qualified: latch peer_id_q = peer_id_s, go to GUESS.
  - Else if counter == TIMEOUT_CYCLES-1: go to PICK, rdy_out=0, link_err=1.
  - If qualification and the terminal count fall in the same cycle, qualification wins.
  - Counter width is $clog2(TIMEOUT_CYCLES). It never wraps.
- GUESS:
  - On guess_valid with guess_id in 1..9: latch guess_q, go to CHECK.
  - Out-of-range guess_id is ignored.
  - If peer_rdy_s=0 or peer_present_s=0 (peer reset or unplugged): go to PICK, rdy_out=0, link_err=1. This takes priority over guess_valid in the same cycle.
- CHECK: lasts exactly one cycle. guess_q == peer_id_q gives WIN with result=2'b10; otherwise LOSE with result=2'b01. The comparison is 4-bit unsigned equality.
- WIN/LOSE:
  - result is held; rdy_out stays 1 so the peer keeps seeing the handshake.
  - Peer input changes are ignored.
  - new_round: go to PICK, result=2'b00, rdy_out=0. id_out keeps its last value.
- pick_valid is ignored outside PICK; guess_valid is ignored outside GUESS; new_round is ignored outside WIN/LOSE.

## Timing
- Every output is a register, with no combinational path from input to output.
- Reset values: state=PICK, state_bin=6'b000001, rdy_out=0, id_out=4'd0, result=2'b00, link_err=0. Synchronisers, counter, own_id, guess_q and peer_id_q all reset to 0.
- Reset mid-round returns immediately to PICK values. The peer sees rdy_out fall and takes its own lost-peer path.
- pick_valid sampled at edge n: state_bin=WAIT_PEER and rdy_out=1 after edge n.
- peer_rdy_in rises before edge k (SYNC_STAGES=2):
  - peer_rdy_s=1 after edge k+1
  - peer_rdy_d=1 after edge k+2
  - state GUESS after edge k+3
  - Handshake latency is therefore SYNC_STAGES+1 edges.
- Timeout: WAIT_PEER entered after edge n. With no peer, state is PICK and link_err=1 after edge n+TIMEOUT_CYCLES.
- guess_valid sampled at edge n: CHECK after edge n; WIN/LOSE and result valid after edge n+1.
- new_round sampled at edge n: PICK with result=00 after edge n.
- A one-cycle peer_rdy_in glitch is never qualified.

## Test plan
- Normal win: reset; pick_id=5; peer_rdy_in=1 with peer_id_in=7 three cycles later; guess_id=7 -> states step PICK→WAIT_PEER→GUESS→CHECK→WIN, result=2'b10, rdy_out=1, id_out=5.
- Lose then restart: same round with guess_id=3 -> LOSE, result=2'b01. Then new_round -> PICK, result=2'b00, rdy_out=0.
- Timeout: TIMEOUT_CYCLES=16; pick_id=2; no peer -> PICK and link_err=1 exactly 16 cycles after WAIT_PEER entry. A following pick clears link_err.
- Glitch/illegal IDs: one-cycle peer_rdy_in pulse -> stays in WAIT_PEER. pick_id=0 or 12 -> stays in PICK. guess_id=15 in GUESS -> stays in GUESS.
- Peer loss priority: in GUESS, drop peer_rdy_in while pulsing guess_valid in the same cycle -> PICK, link_err=1, result=00.
- Async reset mid-WIN: assert rst between clock edges -> all outputs take reset values immediately, without waiting for a clock edge.
